// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage register with synchronous flush; skid entry built when `PIPE_STAGE_SKID_EN is defined.
// Latency: 1 cycle from input accept to o_valid/o_data; full throughput while i_ready=1.
// Backpressure: skid build registers o_ready and absorbs one beat after i_ready drops; default build o_ready = i_ready | ~o_valid.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH       = 97,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic             in_fire;
    logic             out_fire;
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = valid_q & i_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;
    logic             ready_q;
    logic             ready_d;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            data_d       = RESET_VALUE;
            skid_valid_d = 1'b0;
            skid_data_d  = RESET_VALUE;
        end else if (out_fire && skid_valid_q) begin
            // o_ready is low here, so no new beat can arrive in the same cycle
            data_d       = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            valid_d = in_fire;
            if (in_fire) begin
                data_d = i_data;
            end
        end else if (in_fire) begin
            if (valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = i_data;
            end else begin
                valid_d = 1'b1;
                data_d  = i_data;
            end
        end
        // Registered copy of ~skid_valid keeps o_ready free of any i_ready path
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VALUE;
            ready_q      <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_count = {1'b0, valid_q} + {1'b0, skid_valid_q};
`else
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_flush) begin
            valid_d = 1'b0;
            data_d  = RESET_VALUE;
        end else if (in_fire) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    assign o_ready = i_ready | ~valid_q;
    assign o_count = {1'b0, valid_q};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule
